token_enq_driver: RTL and testbench

- Producer-side driver for the dataless token FIFOs (FULL_N/ENQ/CLR enqueue interface).
- Accepts a burst request of N tokens and issues exactly N single-cycle ENQ strobes, each only when FULL_N is high, with an optional minimum idle gap between strobes.
- Supports abort with downstream flush via CLR.
- Sits between a rule-level requester and the enqueue side of a depth-2 (or deeper) zero-width FIFO.

---
 rtl/token_enq_if.sv | 25 ++
 rtl/token_enq_driver.sv | 92 +++++++++
 tb/tb_token_enq_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/token_enq_if.sv
// Enqueue-side bundle between a burst requester, the token driver and a dataless FIFO.
// The master view is the driver itself; the slave view is the requester/FIFO environment.
interface token_enq_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 START;
  logic [CNT_WIDTH-1:0] COUNT;
  logic                 ABORT;
  logic                 FULL_N;
  logic                 ENQ;
  logic                 CLR;
  logic                 BUSY;
  logic                 DONE;
  logic [CNT_WIDTH-1:0] REMAINING;

  modport master (
    input  START, COUNT, ABORT, FULL_N,
    output ENQ, CLR, BUSY, DONE, REMAINING
  );

  modport slave (
    output START, COUNT, ABORT, FULL_N,
    input  ENQ, CLR, BUSY, DONE, REMAINING
  );
endinterface

// File: rtl/token_enq_driver.sv
// Producer-side burst driver for dataless token FIFOs: issues COUNT single-cycle ENQ
// strobes gated by FULL_N, with optional idle gap between strobes and abort-with-CLR.
module token_enq_driver #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned MIN_GAP   = 0
) (
  input  logic        CLK,
  input  logic        RST,
  token_enq_if.master bus
);

  localparam int unsigned GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [GW-1:0]        gap_q;
  logic                 done_q;
  logic                 clr_q;
  logic                 enq;

  // Strobe is combinational from FULL_N so a ready FIFO is filled with zero added latency.
  assign enq = (state_q == SEND) && (rem_q != '0) && bus.FULL_N && !bus.ABORT && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      if (bus.ABORT) begin
        state_q <= IDLE;
        rem_q   <= '0;
        gap_q   <= '0;
        clr_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.START) begin
              if (bus.COUNT != '0) begin
                rem_q   <= bus.COUNT;
                state_q <= SEND;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          SEND: begin
            if (enq) begin
              rem_q <= rem_q - CNT_WIDTH'(1);
              if (rem_q == CNT_WIDTH'(1)) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else if (MIN_GAP != 0) begin
                state_q <= GAP;
                gap_q   <= GW'(MIN_GAP);
              end
            end
          end
          GAP: begin
            gap_q <= gap_q - GW'(1);
            if (gap_q <= GW'(1)) state_q <= SEND;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ENQ       = enq;
  assign bus.CLR       = clr_q;
  assign bus.DONE      = done_q;
  assign bus.BUSY      = (state_q == SEND) || (state_q == GAP);
  assign bus.REMAINING = rem_q;

`ifndef SYNTHESIS
  a_enq_when_full: assert property (@(posedge CLK) disable iff (RST) !(bus.ENQ && !bus.FULL_N))
    else $warning("token_enq_driver: ENQ asserted while FULL_N low");
  a_start_when_busy: assert property (@(posedge CLK) disable iff (RST) !(bus.START && bus.BUSY))
    else $warning("token_enq_driver: START ignored while BUSY");
`endif

endmodule

// File: tb/tb_token_enq_driver.sv
// Bench for token_enq_driver: two instances (MIN_GAP 0 and 2) share stimulus and are
// compared every cycle against a timestamp-based burst model, plus directed end-of-burst totals.
module tb_token_enq_driver;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, full_n;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  token_enq_if #(.CNT_WIDTH(CW)) if0 ();
  token_enq_if #(.CNT_WIDTH(CW)) if2 ();

  assign if0.START  = start;
  assign if0.COUNT  = count;
  assign if0.ABORT  = abort;
  assign if0.FULL_N = full_n;
  assign if2.START  = start;
  assign if2.COUNT  = count;
  assign if2.ABORT  = abort;
  assign if2.FULL_N = full_n;

  token_enq_driver #(.CNT_WIDTH(CW), .MIN_GAP(0)) u_gap0 (.CLK(clk), .RST(rst), .bus(if0));
  token_enq_driver #(.CNT_WIDTH(CW), .MIN_GAP(2)) u_gap2 (.CLK(clk), .RST(rst), .bus(if2));

  always #5 clk = ~clk;

  // Model: a burst is a count of tokens owed plus the earliest cycle the next strobe may issue.
  int gap_of[2] = '{0, 2};
  bit m_busy[2];
  int m_rem[2];
  int m_next[2];
  bit m_done[2];
  bit m_clr[2];
  int cyc = 0;
  int enq_total[2];
  int done_total[2];
  int clr_total[2];

  function automatic bit exp_enq(int g);
    return !rst && m_busy[g] && (m_rem[g] > 0) && full_n && !abort && (cyc >= m_next[g]);
  endfunction

  task automatic chk(string tag, int g, int obs, int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[gap%0d] cycle %0d: observed %0d expected %0d", tag, gap_of[g], cyc, obs, exp);
    end
  endtask

  task automatic check_unit(int g, logic enq, logic clr, logic done, logic busy, logic [CW-1:0] rem);
    chk("ENQ", g, int'(enq), int'(exp_enq(g)));
    chk("CLR", g, int'(clr), int'(m_clr[g]));
    chk("DONE", g, int'(done), int'(m_done[g]));
    chk("BUSY", g, int'(busy), int'(m_busy[g]));
    chk("REMAINING", g, int'(rem), m_rem[g]);
    if (enq === 1'b1) enq_total[g]++;
    if (done === 1'b1) done_total[g]++;
    if (clr === 1'b1) clr_total[g]++;
  endtask

  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      bit e;
      e = exp_enq(g);
      if (rst) begin
        m_busy[g] = 0; m_rem[g] = 0; m_done[g] = 0; m_clr[g] = 0;
      end else begin
        m_done[g] = 0;
        m_clr[g]  = 0;
        if (abort) begin
          m_busy[g] = 0; m_rem[g] = 0; m_clr[g] = 1;
        end else if (!m_busy[g]) begin
          if (start) begin
            if (count == 0) m_done[g] = 1;
            else begin
              m_busy[g] = 1; m_rem[g] = int'(count); m_next[g] = cyc + 1;
            end
          end
        end else if (e) begin
          m_rem[g]--;
          m_next[g] = cyc + 1 + gap_of[g];
          if (m_rem[g] == 0) begin
            m_busy[g] = 0; m_done[g] = 1;
          end
        end
      end
    end
  endtask

  // One clock: inputs already set after negedge; check just before posedge, then advance.
  task automatic step(bit do_check = 1);
    #1;
    if (do_check) begin
      check_unit(0, if0.ENQ, if0.CLR, if0.DONE, if0.BUSY, if0.REMAINING);
      check_unit(1, if2.ENQ, if2.CLR, if2.DONE, if2.BUSY, if2.REMAINING);
    end
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_totals();
    for (int g = 0; g < 2; g++) begin
      enq_total[g] = 0; done_total[g] = 0; clr_total[g] = 0;
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; full_n = 1'b1; count = '0;
  endtask

  initial begin
    bit fpat[7] = '{1, 0, 0, 1, 1, 0, 1};
    @(negedge clk);
    // Reset held two cycles with a pending request: no ENQ may leak out.
    rst = 1'b1; start = 1'b1; count = 8'd5; abort = 1'b0; full_n = 1'b1;
    step(0);
    chk("ENQ_in_reset", 0, int'(if0.ENQ), 0);
    step();
    rst = 1'b0; idle_inputs();
    step();

    // Plain burst of 3 on both gap settings.
    clear_totals();
    start = 1'b1; count = 8'd3; step(); idle_inputs();
    for (int i = 0; i < 9; i++) step();
    chk("burst3_enq_total", 0, enq_total[0], 3);
    chk("burst3_enq_total", 1, enq_total[1], 3);
    chk("burst3_done_total", 0, done_total[0], 1);
    chk("burst3_done_total", 1, done_total[1], 1);

    // Backpressure pattern on a burst of 4.
    clear_totals();
    start = 1'b1; count = 8'd4; step(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin full_n = fpat[i]; step(); end
    full_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("fullpat_enq_total", 0, enq_total[0], 4);
    chk("fullpat_enq_total", 1, enq_total[1], 4);

    // Abort mid-burst of 10: one CLR, no DONE, count cut short.
    clear_totals();
    start = 1'b1; count = 8'd10; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    abort = 1'b1; step(); abort = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("abort_enq_total", 0, enq_total[0], 3);
    chk("abort_clr_total", 0, clr_total[0], 1);
    chk("abort_done_total", 0, done_total[0], 0);
    chk("abort_clr_total", 1, clr_total[1], 1);

    // Abort held 3 cycles in IDLE with START: three CLRs, START discarded.
    clear_totals();
    abort = 1'b1; start = 1'b1; count = 8'd2;
    for (int i = 0; i < 3; i++) step();
    idle_inputs(); step(); step();
    chk("abort_hold_clr_total", 0, clr_total[0], 3);
    chk("abort_hold_enq_total", 0, enq_total[0], 0);

    // Zero-length burst, then a START while busy that must be ignored.
    clear_totals();
    start = 1'b1; count = 8'd0; step(); idle_inputs(); step();
    chk("zero_done_total", 0, done_total[0], 1);
    start = 1'b1; count = 8'd3; step();
    count = 8'd2; step(); step(); start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("busy_start_enq_total", 0, enq_total[0], 3);
    chk("busy_start_enq_total", 1, enq_total[1], 3);

    // Back-to-back bursts: START accepted in the DONE cycle.
    clear_totals();
    start = 1'b1; count = 8'd2; step(); start = 1'b0; step(); step();
    start = 1'b1; count = 8'd1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("b2b_enq_total", 0, enq_total[0], 3);
    chk("b2b_done_total", 0, done_total[0], 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 3) == 0);
      count  = CW'($urandom_range(0, 6));
      abort  = ($urandom_range(0, 29) == 0);
      full_n = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0; idle_inputs();
    for (int i = 0; i < 20; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
